mem_bist: RTL and testbench

MEM_BIST -- requirements
Module: mem_bist

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_bist_cmp.sv | 43 ++++
 rtl/mem_bist.sv | 182 ++++++++++++++++++
 tb/tb_mem_bist.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory BIST: FSM states, default widths and
// the expected-data generator used by both the write and check phases.
package mem_pkg;

   localparam int unsigned DEF_ADDR_W  = 2;
   localparam int unsigned DEF_DATA_W  = 8;
   localparam logic [7:0]  DEF_PATTERN = 8'hAA;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      CHECK,
      DONE
   } state_t;

   // Test word for a location: pattern XOR index, optionally inverted.
   // Callers truncate the 32-bit result to their own data width.
   function automatic logic [31:0] exp_word(input logic [31:0] pattern,
                                            input logic [31:0] idx,
                                            input logic        inv);
      logic [31:0] w;
      w = pattern ^ idx;
      return inv ? ~w : w;
   endfunction

endpackage

// File: rtl/mem_bist_cmp.sv
// Read-data checker for the memory BIST: compares returned data against the
// expected word, keeps a saturating mismatch count and records the address
// of the first mismatch since the last clear.
module mem_bist_cmp
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              check_en,
   input  logic [DATA_W-1:0] rdata,
   input  logic [DATA_W-1:0] expected,
   input  logic [ADDR_W-1:0] idx,
   output logic              mismatch,
   output logic [3:0]        err_cnt,
   output logic [ADDR_W-1:0] fail_addr
);

   // Mismatch is only meaningful in the cycle the FSM enables the check.
   always_comb begin
      mismatch = check_en && (rdata != expected);
   end

   // Saturating error count; a zero count means no mismatch seen yet, so
   // it doubles as the "first failure" qualifier for fail_addr.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         err_cnt   <= '0;
         fail_addr <= '0;
      end else if (mismatch) begin
         if (err_cnt != 4'hF) begin
            err_cnt <= err_cnt + 4'd1;
         end
         if (err_cnt == 4'd0) begin
            fail_addr <= idx;
         end
      end
   end

endmodule

// File: rtl/mem_bist.sv
// Memory built-in self-test controller. Writes PATTERN^idx to every
// location, then reads each back and checks it. With MEM_BIST_MARCH_EN
// defined, a second write/read/check pass with inverted data runs before
// DONE. All memory-side outputs are registered.
module mem_bist
   import mem_pkg::*;
#(
   parameter int unsigned       ADDR_W  = DEF_ADDR_W,
   parameter int unsigned       DATA_W  = DEF_DATA_W,
   parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEF_PATTERN)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] addr,
   output logic              wr_en,
   output logic              rd_en,
   output logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [3:0]        err_cnt,
   output logic [ADDR_W-1:0] fail_addr
);

   localparam logic [ADDR_W-1:0] LAST_IDX = '1;

   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic              clear;
   logic              check_en;
   logic              mismatch;
   logic [DATA_W-1:0] expected;
   logic              inv_sel;

`ifdef MEM_BIST_MARCH_EN
   logic pass_sel;
   assign inv_sel = pass_sel;
`else
   assign inv_sel = 1'b0;
`endif

   function automatic logic [DATA_W-1:0] word(input logic [ADDR_W-1:0] i,
                                              input logic              inv);
      return DATA_W'(exp_word(32'(PATTERN), 32'(i), inv));
   endfunction

   // Checker control: clear on an accepted start, compare only in CHECK.
   always_comb begin
      clear    = (state == IDLE) && start && !abort && !reset;
      check_en = (state == CHECK) && !abort && !reset;
      expected = word(idx, inv_sel);
   end

   mem_bist_cmp #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_cmp (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .check_en (check_en),
      .rdata    (rdata),
      .expected (expected),
      .idx      (idx),
      .mismatch (mismatch),
      .err_cnt  (err_cnt),
      .fail_addr(fail_addr)
   );

   // FSM with registered outputs: each branch loads the outputs the memory
   // must see in the state being entered, so strobes line up with state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         idx   <= '0;
         addr  <= '0;
         wdata <= '0;
         wr_en <= 1'b0;
         rd_en <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         pass  <= 1'b0;
`ifdef MEM_BIST_MARCH_EN
         pass_sel <= 1'b0;
`endif
      end else if (abort && (state != IDLE)) begin
         state <= IDLE;
         idx   <= '0;
         wr_en <= 1'b0;
         rd_en <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         pass  <= 1'b0;
`ifdef MEM_BIST_MARCH_EN
         pass_sel <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  state <= WRITE;
                  idx   <= '0;
                  busy  <= 1'b1;
                  pass  <= 1'b0;
                  wr_en <= 1'b1;
                  addr  <= '0;
                  wdata <= word('0, 1'b0);
`ifdef MEM_BIST_MARCH_EN
                  pass_sel <= 1'b0;
`endif
               end
            end

            WRITE: begin
               if (idx == LAST_IDX) begin
                  state <= READ;
                  idx   <= '0;
                  wr_en <= 1'b0;
                  rd_en <= 1'b1;
                  addr  <= '0;
               end else begin
                  idx   <= idx + 1'b1;
                  addr  <= idx + 1'b1;
                  wdata <= word(idx + 1'b1, inv_sel);
               end
            end

            READ: begin
               state <= CHECK;
               rd_en <= 1'b0;
            end

            CHECK: begin
               if (idx == LAST_IDX) begin
`ifdef MEM_BIST_MARCH_EN
                  if (!pass_sel) begin
                     state    <= WRITE;
                     pass_sel <= 1'b1;
                     idx      <= '0;
                     wr_en    <= 1'b1;
                     addr     <= '0;
                     wdata    <= word('0, 1'b1);
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                     pass  <= (err_cnt == 4'd0) && !mismatch;
                  end
`else
                  state <= DONE;
                  done  <= 1'b1;
                  // err_cnt updates on this same edge, so fold in the last check
                  pass  <= (err_cnt == 4'd0) && !mismatch;
`endif
               end else begin
                  state <= READ;
                  idx   <= idx + 1'b1;
                  rd_en <= 1'b1;
                  addr  <= idx + 1'b1;
               end
            end

            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end

            default: begin
               state <= IDLE;
               wr_en <= 1'b0;
               rd_en <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bist.sv
// Directed testbench for mem_bist with a behavioural memory model that can
// inject stuck-at faults, and scoreboards for write traffic and run results.
module tb_mem_bist;

   localparam int unsigned ADDR_W = 2;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 4;
`ifdef MEM_BIST_MARCH_EN
   localparam int NPASS = 2;
`else
   localparam int NPASS = 1;
`endif
   localparam int RUN_LEN = NPASS * 3 * DEPTH + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } wr_t;

   typedef struct {
      logic       pass;
      logic [3:0] err;
      logic [1:0] fail;
      int         len;
   } res_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] addr;
   logic              wr_en;
   logic              rd_en;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata = '0;
   logic              busy;
   logic              done;
   logic              pass;
   logic [3:0]        err_cnt;
   logic [ADDR_W-1:0] fail_addr;

   logic [DATA_W-1:0] mem [DEPTH];
   int                fault_mode = 0;
   int                n_assert = 0;
   int                n_fail = 0;
   wr_t               wq[$];
   res_t              rq[$];

   mem_bist #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .PATTERN(8'hAA)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .abort    (abort),
      .addr     (addr),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .wdata    (wdata),
      .rdata    (rdata),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .err_cnt  (err_cnt),
      .fail_addr(fail_addr)
   );

   always #5 clk = ~clk;

   // 0: fault-free, 1: bit0 of address 2 stuck at 1, 2: all bits stuck at 0
   function automatic logic [DATA_W-1:0] faulty(input logic [DATA_W-1:0] d,
                                                input logic [ADDR_W-1:0] a);
      case (fault_mode)
         1:       return (a == 2'd2) ? (d | 8'h01) : d;
         2:       return '0;
         default: return d;
      endcase
   endfunction

   // Synchronous memory: read data appears the cycle after rd_en.
   always @(posedge clk) begin
      if (wr_en) mem[addr] <= wdata;
      if (rd_en) rdata <= faulty(mem[addr], addr);
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values();
      check("rst_addr", 32'(addr), 0);
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_rd_en", 32'(rd_en), 0);
      check("rst_wdata", 32'(wdata), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_pass", 32'(pass), 0);
      check("rst_err_cnt", 32'(err_cnt), 0);
      check("rst_fail_addr", 32'(fail_addr), 0);
   endtask

   // Full run: queue expected writes and result, pulse start, then watch
   // the DUT until done (bounded), scoring writes and the final result.
   task automatic run_check(input int fmode, input logic exp_pass,
                            input logic [3:0] exp_err, input logic [1:0] exp_fail,
                            input bit start_in_done);
      int   n;
      bit   seen;
      res_t r;
      wr_t  w;
      logic [DATA_W-1:0] d;
      fault_mode = fmode;
      for (int p = 0; p < NPASS; p++) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            d = 8'hAA ^ 8'(i);
            if (p == 1) d = ~d;
            wq.push_back(wr_t'{a: 2'(i), d: d});
         end
      end
      rq.push_back('{pass: exp_pass, err: exp_err, fail: exp_fail, len: RUN_LEN});
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      seen = 0;
      while (!seen && n <= RUN_LEN + 10) begin
         check("wr_rd_excl", 32'(wr_en && rd_en), 0);
         if (wr_en) begin
            if (wq.size() > 0) begin
               w = wq.pop_front();
               check("wr_addr", 32'(addr), 32'(w.a));
               check("wr_data", 32'(wdata), 32'(w.d));
            end else begin
               check("wr_extra", 32'(wr_en), 0);
            end
         end
         if (done) begin
            seen = 1;
            r = rq.pop_front();
            check("done_cycle", n, r.len);
            check("done_busy", 32'(busy), 1);
            check("done_pass", 32'(pass), 32'(r.pass));
            check("done_err_cnt", 32'(err_cnt), 32'(r.err));
            check("done_fail_addr", 32'(fail_addr), 32'(r.fail));
            check("done_strobes", 32'({wr_en, rd_en}), 0);
         end else begin
            @(negedge clk);
            n++;
         end
      end
      if (!seen) begin
         check("done_timeout", 32'(done), 1);
         rq.delete();
      end
      check("writes_left", wq.size(), 0);
      wq.delete();
      if (start_in_done) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("post_busy", 32'(busy), 0);
      check("post_done", 32'(done), 0);
      check("post_pass_hold", 32'(pass), 32'(exp_pass));
      @(negedge clk);
      check("post2_busy", 32'(busy), 0);
      check("post2_wr_en", 32'(wr_en), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int nrd;
      int cyc;
      int ndone;

      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check_reset_values();

      // Fault-free run, with a start pulse landing in the DONE cycle
      run_check(0, 1'b1, 4'd0, 2'd0, 1'b1);

      // Bit0 of address 2 stuck at 1: inverted pass has bit0 already set
      run_check(1, 1'b0, 4'd1, 2'd2, 1'b0);

      // All bits stuck at 0: every check fails, first at address 0
      run_check(2, 1'b0, 4'(4 * NPASS), 2'd0, 1'b0);

      // Abort during the second READ
      fault_mode = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nrd = 0;
      cyc = 0;
      while (nrd < 2 && cyc < 40) begin
         if (rd_en) nrd++;
         if (nrd < 2) begin
            @(negedge clk);
            cyc++;
         end
      end
      check("abort_at_read", 32'(rd_en), 1);
      check("abort_read_addr", 32'(addr), 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 32'(busy), 0);
      check("abort_rd_en", 32'(rd_en), 0);
      check("abort_wr_en", 32'(wr_en), 0);
      check("abort_done", 32'(done), 0);
      check("abort_pass", 32'(pass), 0);
      check("abort_err_hold", 32'(err_cnt), 0);
      ndone = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abort_no_done", ndone, 0);

      // Abort and start together in IDLE: abort wins
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("abort_start_busy", 32'(busy), 0);
      check("abort_start_wr_en", 32'(wr_en), 0);

      // Two start pulses four cycles apart: second one lands mid-run
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      repeat (RUN_LEN + 20) begin
         if (done) begin
            ndone++;
            check("dbl_start_pass", 32'(pass), 1);
         end
         @(negedge clk);
      end
      check("dbl_start_done_count", ndone, 1);

      // One-cycle reset in the middle of WRITE
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("pre_reset_wr_en", 32'(wr_en), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_values();
      ndone = 0;
      repeat (RUN_LEN + 5) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("reset_no_done", ndone, 0);
      run_check(0, 1'b1, 4'd0, 2'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
